// File: rtl/write_axi_stream.sv
// Captures NUM_CH-sample frames on the rising edge of a synchronised recovery strobe,
// buffers them in a frame FIFO and serialises them one channel per AXI-Stream beat.
module write_axi_stream #(
  parameter int DATA_W      = 14,
  parameter int NUM_CH      = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int OFFSET_BIN  = 0
) (
  input  logic                                  clock_50,
  input  logic                                  reset,
  input  logic                                  clock_recovery,
  input  logic [NUM_CH*DATA_W-1:0]              data_rec,
  input  logic                                  clr_ovf,
  input  logic                                  m_tready,
  output logic                                  m_tvalid,
  output logic [DATA_W-1:0]                     m_tdata,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] m_tuser,
  output logic                                  m_tlast,
  output logic [NUM_CH*DATA_W-1:0]              data_stand,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fill,
  output logic                                  overflow
);
  localparam int FRAME_W = NUM_CH * DATA_W;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FILL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [FILL_W-1:0] FULL    = FILL_W'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] FLIP    = (OFFSET_BIN != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  typedef enum logic {IDLE, SEND} state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic                   capture, push, drop, pop, advance;
  logic [FRAME_W-1:0]     conv_frame;
  logic [FRAME_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [FILL_W-1:0]      fill_reg;
  logic                   overflow_reg;
  logic [FRAME_W-1:0]     data_stand_reg, frame_reg;
  logic [CH_W-1:0]        ch_reg, ch_next;
  logic                   tvalid_reg, tvalid_next;
  state_t                 state_reg, state_next;

  // Flops reset high so a strobe already high at reset release is not seen as an edge.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      sync_reg <= '1;
      hist_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], clock_recovery};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign capture = sync_reg[SYNC_STAGES-1] & ~hist_reg;
  assign push    = capture & (fill_reg != FULL);
  assign drop    = capture & (fill_reg == FULL);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_conv
      assign conv_frame[gi*DATA_W +: DATA_W] = data_rec[gi*DATA_W +: DATA_W] ^ FLIP;
    end
  endgenerate

  always_ff @(posedge clock_50) begin
    if (push) mem[wr_ptr_reg] <= conv_frame;
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fill_reg       <= '0;
      overflow_reg   <= 1'b0;
      data_stand_reg <= '0;
    end else begin
      if (capture) data_stand_reg <= conv_frame;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      fill_reg <= fill_reg + 1'b1;
      else if (pop && !push) fill_reg <= fill_reg - 1'b1;
      if (drop)         overflow_reg <= 1'b1;
      else if (clr_ovf) overflow_reg <= 1'b0;
    end
  end

  // In SEND m_tvalid is always high, so m_tready alone marks a handshake.
  always_comb begin
    state_next  = state_reg;
    ch_next     = ch_reg;
    tvalid_next = tvalid_reg;
    pop         = 1'b0;
    advance     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fill_reg != '0) begin
          pop         = 1'b1;
          ch_next     = '0;
          tvalid_next = 1'b1;
          state_next  = SEND;
        end
      end
      SEND: begin
        if (m_tready) begin
          if (ch_reg != LAST_CH) begin
            ch_next = ch_reg + 1'b1;
            advance = 1'b1;
          end else if (fill_reg != '0) begin
            pop     = 1'b1;
            ch_next = '0;
          end else begin
            tvalid_next = 1'b0;
            state_next  = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_reg  <= IDLE;
      ch_reg     <= '0;
      tvalid_reg <= 1'b0;
      frame_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      ch_reg     <= ch_next;
      tvalid_reg <= tvalid_next;
      if (pop)          frame_reg <= mem[rd_ptr_reg];
      else if (advance) frame_reg <= frame_reg >> DATA_W;
    end
  end

  assign m_tvalid   = tvalid_reg;
  assign m_tdata    = frame_reg[DATA_W-1:0];
  assign m_tuser    = ch_reg;
  assign m_tlast    = tvalid_reg & (ch_reg == LAST_CH);
  assign data_stand = data_stand_reg;
  assign fill       = fill_reg;
  assign overflow   = overflow_reg;
endmodule

// File: tb/tb_write_axi_stream.sv
// Directed bench for write_axi_stream: a plain instance and an offset-binary instance
// share all stimulus; expected values are hand-derived constants.
module tb_write_axi_stream;
  logic        clk = 1'b0;
  logic        reset, clock_recovery, clr_ovf, m_tready;
  logic [27:0] data_rec;
  logic        tvalid, tlast, ovf, ob_tvalid, ob_tlast, ob_ovf;
  logic [13:0] tdata, ob_tdata;
  logic [0:0]  tuser, ob_tuser;
  logic [27:0] stand, ob_stand;
  logic [3:0]  fill, ob_fill;
  int          passed = 0;
  int          total  = 0;

  always #10 clk = ~clk;

  write_axi_stream #(.OFFSET_BIN(0)) dut (
    .clock_50(clk), .reset(reset), .clock_recovery(clock_recovery), .data_rec(data_rec),
    .clr_ovf(clr_ovf), .m_tready(m_tready), .m_tvalid(tvalid), .m_tdata(tdata),
    .m_tuser(tuser), .m_tlast(tlast), .data_stand(stand), .fill(fill), .overflow(ovf));

  write_axi_stream #(.OFFSET_BIN(1)) dut_ob (
    .clock_50(clk), .reset(reset), .clock_recovery(clock_recovery), .data_rec(data_rec),
    .clr_ovf(clr_ovf), .m_tready(m_tready), .m_tvalid(ob_tvalid), .m_tdata(ob_tdata),
    .m_tuser(ob_tuser), .m_tlast(ob_tlast), .data_stand(ob_stand), .fill(ob_fill),
    .overflow(ob_ovf));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Strobe high for three edges (captured at the third), then low for three.
  task automatic strobe_frame(input logic [27:0] d);
    data_rec = d;
    clock_recovery = 1'b1;
    tick(3);
    clock_recovery = 1'b0;
    tick(3);
  endtask

  function automatic logic [27:0] fr(input int n);
    return {14'(n + 'h100), 14'(n)};
  endfunction

  initial begin
    reset = 1'b1; clock_recovery = 1'b0; clr_ovf = 1'b0; m_tready = 1'b0; data_rec = '0;
    tick(3);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser", tuser, 0);
    check("rst_tlast", tlast, 0);
    check("rst_stand", stand, 0);
    check("rst_fill", fill, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ob_misc", {ob_tvalid, ob_tlast, ob_tuser, ob_fill, ob_ovf}, 0);
    reset = 1'b0;
    tick(4);

    // Basic capture: strobe rises before edge 1, captured at edge 3.
    data_rec = {14'h0123, 14'h2ABC}; m_tready = 1'b1; clock_recovery = 1'b1;
    tick(2);
    check("early_stand", stand, 0);
    tick();
    check("cap_stand", stand, {14'h0123, 14'h2ABC});
    check("cap_ob_stand", ob_stand, {14'h2123, 14'h0ABC});
    check("cap_fill", fill, 1);
    check("cap_tvalid", tvalid, 0);
    clock_recovery = 1'b0;
    tick();
    check("b1_tvalid", tvalid, 1);
    check("b1_tdata", tdata, 14'h2ABC);
    check("b1_tuser", tuser, 0);
    check("b1_tlast", tlast, 0);
    check("b1_fill", fill, 0);
    check("b1_ob", {ob_tvalid, ob_tuser, ob_tlast, ob_tdata}, {1'b1, 1'b0, 1'b0, 14'h0ABC});
    tick();
    check("b2_tvalid", tvalid, 1);
    check("b2_tdata", tdata, 14'h0123);
    check("b2_tuser", tuser, 1);
    check("b2_tlast", tlast, 1);
    tick();
    check("b_done_tvalid", tvalid, 0);
    tick(3);

    // Offset-binary conversion under backpressure.
    m_tready = 1'b0;
    strobe_frame({14'h1FFF, 14'h2000});
    check("ob_stand", ob_stand, {14'h3FFF, 14'h0000});
    check("bp_tvalid", tvalid, 1);
    check("bp_tdata", tdata, 14'h2000);
    check("ob_b1_tdata", ob_tdata, 14'h0000);
    tick(5);
    check("bp_hold", {tvalid, tuser, tlast, tdata}, {1'b1, 1'b0, 1'b0, 14'h2000});
    m_tready = 1'b1;
    tick();
    check("bp_b2", {tvalid, tuser, tlast, tdata}, {1'b1, 1'b1, 1'b1, 14'h1FFF});
    check("ob_b2_tdata", ob_tdata, 14'h3FFF);
    tick();
    check("bp_done", tvalid, 0);

    // Overflow: frame 1 sits in the output register, frames 2..9 fill the FIFO,
    // frame 10 is dropped.
    m_tready = 1'b0;
    for (int n = 1; n <= 9; n++) strobe_frame(fr(n));
    check("ovf_fill8", fill, 8);
    check("ovf_not_yet", ovf, 0);
    strobe_frame(fr(10));
    check("ovf_set", ovf, 1);
    check("ovf_fill", fill, 8);
    check("ovf_stand", stand, fr(10));
    tick(2);
    check("ovf_sticky", ovf, 1);
    m_tready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      check($sformatf("drain%0d_tvalid", k), tvalid, 1);
      check($sformatf("drain%0d_tdata", k), tdata,
            (k % 2 == 1) ? 14'(k / 2 + 1 + 'h100) : 14'(k / 2 + 1));
      check($sformatf("drain%0d_tlast", k), {tuser, tlast}, (k % 2 == 1) ? 2'b11 : 2'b00);
      tick();
    end
    check("drain_end_tvalid", tvalid, 0);
    check("drain_end_fill", fill, 0);
    check("drain_ovf_kept", ovf, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", ovf, 0);

    // Reset mid-frame with the strobe held high across release.
    m_tready = 1'b0;
    strobe_frame(fr(20));
    strobe_frame(fr(21));
    check("mid_fill", fill, 1);
    m_tready = 1'b1;
    tick();
    check("mid_beat2", {tvalid, tuser, tdata}, {1'b1, 1'b1, 14'h114});
    clock_recovery = 1'b1;
    reset = 1'b1;
    tick();
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_fill", fill, 0);
    tick();
    reset = 1'b0;
    tick(6);
    check("post_rst_tvalid", tvalid, 0);
    check("post_rst_fill", fill, 0);
    check("post_rst_stand", stand, 0);
    clock_recovery = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
